mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares one registered output channel between N valid/ready requesters. It sequences the select of an N-way data multiplexer from a rotating-priority pointer. It optionally locks the grant for a whole multi-beat packet. It sits between several producer blocks and a single downstream consumer, and is the sequential controller for the mux datapath.

## Interface
- N, default 4: number of requesters; N >= 2, any value (not restricted to powers of two).
- W, default 8: data width per requester.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_vld  in  N  request valid, one bit per requester.
- req_data  in  N*W  requester i data at [i*W +: W].
- req_last  in  N  last beat of packet, per requester.
- req_rdy  out  N  per-requester ready; at most one bit set.
- out_vld  out  1  registered output valid.
- out_data  out  W  registered output data.
- out_last  out  1  registered last flag.
- out_id  out  $clog2(N)  index of the source of the current output beat.
- out_rdy  in  1  downstream ready.

## Operation
- Reset values:
  - out_vld=0, out_data=0, out_last=0, out_id=0.
  - Round-robin pointer ptr=0.
  - state=ARB_IDLE.
- Output stage: single register; `slot_free = !out_vld || out_rdy`.
- Grant g in ARB_IDLE:
  - g is the first i with req_vld[i], scanning ptr, ptr+1, … and wrapping at N-1 to 0.
  - No valid request means no grant, and all req_rdy bits are 0.
- Grant in ARB_LOCKED: g = lock_id, regardless of other requests.
- Ready and accept:
  - req_rdy[g] = slot_free (ARB_IDLE requires a grant to exist). All other req_rdy bits are 0.
  - Accept = req_vld[g] && req_rdy[g].
  - req_rdy depends combinationally on out_rdy and req_vld.
- On accept:
  - out_data <= req_data[g], out_last <= req_last[g], out_id <= g, out_vld <= 1.
- On out_rdy with no accept: out_vld <= 0. The data registers hold their value.
- Pointer update:
  - With lock disabled: ptr <= (g+1) mod N on every accept.
  - With lock enabled: ptr updates only on an accept with req_last[g]=1.
- State machine (lock enabled):
  - ARB_IDLE: accept with req_last=0 → ARB_LOCKED, lock_id <= g.
  - ARB_LOCKED: accept with req_last=1 → ARB_IDLE.
  - Otherwise the state holds.
- Boundary conditions:
  - Locked requester drops req_vld: no accept, the lock holds, and the others remain stalled.
  - All requesters valid every cycle: grants rotate 0,1,…,N-1,0.
  - ptr=N-1 wraps to 0.
  - Simultaneous out_rdy and accept: the old beat leaves and the new beat loads in the same cycle, giving full throughput.
  - Asynchronous reset mid-packet: lock cleared, ptr=0, the in-flight output beat is dropped.

## Timing
- Latency is 1 cycle from accept edge to out_vld/out_data.
- Throughput is 1 beat/cycle when out_rdy is held at 1.
- Zero-cycle arbitration: the grant and req_rdy settle in the same cycle as req_vld.
- out_* is stable while out_vld=1 && out_rdy=0. Upstream must hold req_* while req_vld=1 && req_rdy=0.

## Configuration
- MUX_RR_ARBITER_PKT_LOCK_EN defined:
  - The ARB_LOCKED state exists, and the grant is held from first beat to the req_last beat.
  - The pointer advances per packet.
- Macro undefined:
  - No state register; the block re-arbitrates every beat and the pointer advances per beat.
  - req_last is still forwarded to out_last, but it has no effect on arbitration.

## Structure
- Package mux_arb_pkg contains:
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e.
  - Function for the wrap increment of the pointer.
- Sub-module mux_arb_rr_pick (combinational): inputs req_vld[N] and ptr; outputs grant index and a grant-found flag.
- Top level contains the state register, pointer, output register and N-way data select indexed by g.

## Test plan
- Single requester: req_vld=4'b0100, data 8'hA5, last=1, out_rdy=1 → req_rdy=4'b0100; next cycle out_vld=1, out_data=A5, out_id=2; ptr=3.
- Fairness: all four valid, last=1, out_rdy=1 for 8 cycles → out_id sequence 0,1,2,3,0,1,2,3 with out_vld continuously 1.
- Backpressure: out_rdy=0 for 3 cycles with a beat held → out_data/out_id stable, req_rdy=0; beat drains and the next loads on the first out_rdy=1 cycle.
- Packet lock (macro on): req1 sends 3 beats (last on beat 3) while req2 is valid throughout → out_id=1,1,1 then 2; with the macro off → 1,2,1,2,…
- Wrap and reset: after an accept from requester 3, ptr=0; assert rst_n=0 mid-lock → out_vld=0 immediately, state ARB_IDLE, next grant starts from requester 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the mux round-robin arbiter.
package mux_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

    // Increment an index modulo n; valid for any n >= 2, not just powers of two.
    function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Rotating-priority picker: first valid requester at or after ptr, wrapping at N-1.
module mux_arb_rr_pick
    import mux_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req_vld,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] grant,
    output logic                 found
);
    localparam int unsigned IW = $clog2(N);

    int unsigned idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 32'(ptr);
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && req_vld[IW'(idx)]) begin
                found = 1'b1;
                grant = IW'(idx);
            end
            idx = rr_wrap_inc(idx, N);
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a registered N-way data mux onto one output channel.
// Define MUX_RR_ARBITER_PKT_LOCK_EN to hold the grant for a whole packet (until req_last).
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_vld,
    input  logic [N*W-1:0]       req_data,
    input  logic [N-1:0]         req_last,
    output logic [N-1:0]         req_rdy,
    output logic                 out_vld,
    output logic [W-1:0]         out_data,
    output logic                 out_last,
    output logic [$clog2(N)-1:0] out_id,
    input  logic                 out_rdy
);
    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] ptr;
    logic [IW-1:0] pick_id;
    logic [IW-1:0] g;
    logic          pick_found;
    logic          grant_ok;
    logic          slot_free;
    logic          accept;
    logic          g_last;
    logic          ptr_adv;
    logic [W-1:0]  g_data;

    assign slot_free = !out_vld || out_rdy;

    mux_arb_rr_pick #(
        .N(N)
    ) u_pick (
        .req_vld (req_vld),
        .ptr     (ptr),
        .grant   (pick_id),
        .found   (pick_found)
    );

`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
    arb_state_e    state;
    logic [IW-1:0] lock_id;

    // While locked the grant is pinned even if the owner drops req_vld.
    always_comb begin
        g        = pick_id;
        grant_ok = pick_found;
        if (state == ARB_LOCKED) begin
            g        = lock_id;
            grant_ok = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            lock_id <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (accept && !g_last) begin
                        state   <= ARB_LOCKED;
                        lock_id <= g;
                    end
                end
                ARB_LOCKED: begin
                    if (accept && g_last)
                        state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign ptr_adv = accept && g_last;
`else
    assign g        = pick_id;
    assign grant_ok = pick_found;
    assign ptr_adv  = accept;
`endif

    always_comb begin
        req_rdy = '0;
        if (grant_ok && slot_free)
            req_rdy[g] = 1'b1;
    end

    assign accept = req_vld[g] && req_rdy[g];
    assign g_data = req_data[g*W +: W];
    assign g_last = req_last[g];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (ptr_adv)
            ptr <= IW'(rr_wrap_inc(32'(g), N));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
            out_id   <= '0;
        end else if (accept) begin
            out_vld  <= 1'b1;
            out_data <= g_data;
            out_last <= g_last;
            out_id   <= g;
        end else if (out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter (N=4, W=8); expectations follow MUX_RR_ARBITER_PKT_LOCK_EN.
module tb_mux_rr_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned IW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_vld;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_rdy;
    logic           out_vld;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [IW-1:0]  out_id;
    logic           out_rdy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;

    logic [7:0] d1 [3] = '{8'h81, 8'h82, 8'h83};
    logic       l1 [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] d2 [2] = '{8'h77, 8'h78};

    always #5 clk = ~clk;

    mux_rr_arbiter #(
        .N(N),
        .W(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_vld  (req_vld),
        .req_data (req_data),
        .req_last (req_last),
        .req_rdy  (req_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_last (out_last),
        .out_id   (out_id),
        .out_rdy  (out_rdy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [7:0] d, input logic l);
        beat_t b;
        b.id   = IW'(id);
        b.data = d;
        b.last = l;
        exp_q.push_back(b);
    endtask

    // A beat is consumed at the next rising edge when out_vld && out_rdy.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_vld === 1'b1 && out_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_beat: got id %0d data %0h, expected no beat", out_id, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_id", 32'(out_id), 32'(mon_e.id));
                check("out_data", 32'(out_data), 32'(mon_e.data));
                check("out_last", 32'(out_last), 32'(mon_e.last));
            end
        end
    end

    initial begin
        int i1;
        int i2;
        logic a1;
        logic a2;

        rst_n    = 1'b0;
        req_vld  = '0;
        req_last = '0;
        req_data = '0;
        out_rdy  = 1'b0;
        #12;
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_id", 32'(out_id), 32'd0);
        check("rst_req_rdy", 32'(req_rdy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single requester
        req_data[2*W +: W] = 8'hA5;
        req_last = '1;
        req_vld  = 4'b0100;
        out_rdy  = 1'b1;
        #1;
        check("single_rdy", 32'(req_rdy), 32'h4);
        push(2, 8'hA5, 1'b1);
        tick();
        req_vld = '0;
        check("single_vld", 32'(out_vld), 32'd1);

        // Fairness from ptr=3
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(8'h10 + i);
        req_vld = '1;
        #1;
        for (int k = 0; k < 8; k++) begin
            push((3 + k) % 4, 8'(8'h10 + (3 + k) % 4), 1'b1);
            tick();
            check("fair_vld", 32'(out_vld), 32'd1);
        end
        req_vld = '0;

        // Backpressure, ptr=3
        req_data[0 +: W] = 8'h3C;
        req_vld = 4'b0001;
        push(0, 8'h3C, 1'b1);
        tick();
        out_rdy = 1'b0;
        req_data[W +: W] = 8'h4D;
        req_vld = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_rdy", 32'(req_rdy), 32'd0);
            check("bp_data", 32'(out_data), 32'h3C);
            check("bp_id", 32'(out_id), 32'd0);
            tick();
        end
        out_rdy = 1'b1;
        #1;
        check("bp_release_rdy", 32'(req_rdy), 32'h2);
        push(1, 8'h4D, 1'b1);
        tick();
        req_vld = '0;

        // Packet lock, ptr=2: req1 3-beat packet, req2 two single-beat packets
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
        push(1, 8'h81, 1'b0);
        push(1, 8'h82, 1'b0);
        push(1, 8'h83, 1'b1);
        push(2, 8'h77, 1'b1);
        push(2, 8'h78, 1'b1);
`else
        push(1, 8'h81, 1'b0);
        push(2, 8'h77, 1'b1);
        push(1, 8'h82, 1'b0);
        push(2, 8'h78, 1'b1);
        push(1, 8'h83, 1'b1);
`endif
        i1 = 0;
        i2 = 0;
        for (int c = 0; c < 20 && (i1 < 3 || i2 < 2); c++) begin
            req_vld = '0;
            if (i1 < 3) begin
                req_vld[1]       = 1'b1;
                req_data[W +: W] = d1[i1];
                req_last[1]      = l1[i1];
            end
            if (c > 0 && i2 < 2) begin
                req_vld[2]         = 1'b1;
                req_data[2*W +: W] = d2[i2];
                req_last[2]        = 1'b1;
            end
            #1;
            a1 = req_rdy[1] && req_vld[1];
            a2 = req_rdy[2] && req_vld[2];
            tick();
            if (a1) i1++;
            if (a2) i2++;
        end
        req_vld = '0;
        if (i1 < 3 || i2 < 2) begin
            n_cmp++;
            n_err++;
            $display("FAIL lock_timeout: got %0d/%0d beats accepted, expected 3/2", i1, i2);
        end

        // Wrap from requester 3, then lock behaviour and reset mid-lock
        req_data[3*W +: W] = 8'h90;
        req_last = '1;
        req_vld  = 4'b1000;
        #1;
        check("wrap_rdy", 32'(req_rdy), 32'h8);
        push(3, 8'h90, 1'b1);
        tick();
        req_data[0 +: W] = 8'hA0;
        req_data[W +: W] = 8'hB1;
        req_last = 4'b0010;
        req_vld  = 4'b0011;
        #1;
        check("wrap_ptr0_rdy", 32'(req_rdy), 32'h1);
        push(0, 8'hA0, 1'b0);
        tick();
        req_vld = 4'b0010;
        #1;
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
        check("lock_hold_rdy", 32'(req_rdy), 32'h1);
`else
        check("rearb_rdy", 32'(req_rdy), 32'h2);
        push(1, 8'hB1, 1'b1);
`endif
        tick();
        out_rdy = 1'b0;
        #1;
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
        check("lock_stall_vld", 32'(out_vld), 32'd0);
        check("lock_stall_rdy", 32'(req_rdy), 32'h1);
`else
        check("stall_vld", 32'(out_vld), 32'd1);
        check("stall_rdy", 32'(req_rdy), 32'd0);
`endif
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_vld", 32'(out_vld), 32'd0);
        check("mid_rst_out_id", 32'(out_id), 32'd0);
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
        check("mid_rst_pending", 32'(exp_q.size()), 32'd0);
`else
        check("mid_rst_pending", 32'(exp_q.size()), 32'd1);
`endif
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_data[W +: W] = 8'hC1;
        req_last = '1;
        req_vld  = 4'b1110;
        out_rdy  = 1'b1;
        #1;
        check("post_rst_rdy", 32'(req_rdy), 32'h2);
        push(1, 8'hC1, 1'b1);
        tick();
        req_vld = '0;

        for (int c = 0; c < 20 && exp_q.size() > 0; c++) tick();
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", exp_q.size());
        end
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
